// File: rtl/bpsk_tx_pkg.sv
// Shared types and constants for the BPSK transmit path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bpsk_tx_pkg;

  // Frame sequencer states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    SYNC     = 3'd2,
    PAYLOAD  = 3'd3,
    CRC      = 3'd4,
    GUARD    = 3'd5
  } tx_state_e;

  localparam logic [7:0] SYNC_WORD = 8'hD3;
  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // One serial step of a non-reflected CRC-8, message bits fed MSB first
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    crc8_step = {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT cycles, flags first and last cycle of each bit.
// Latency: bit_strobe_o is combinational from the count; restart_i takes effect next cycle.
// Backpressure: none; restart_i holds the counter at zero.
module bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic bit_strobe_o,
  output logic bit_end_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_strobe_o = (cnt_q == '0);
  assign bit_end_o    = (cnt_q == LAST);

  // Wrap at the end of each bit period; restart forces the next cycle to be a bit start
  always_comb begin
    if (restart_i || bit_end_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Cycle counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/packet_tx_sequencer.sv
// Packet-to-serial frame sequencer: preamble, sync, payload, optional CRC-8 (PACKET_TX_CRC8_EN), guard gap.
// Latency: first preamble bit one cycle after the accepting packet_valid rising edge.
// Backpressure: none; a rising packet_valid while busy drops the packet and sets sticky overrun.
module packet_tx_sequencer
  import bpsk_tx_pkg::*;
#(
  parameter int PACKET_WIDTH  = 4,
  parameter int CLKS_PER_BIT  = 16,
  parameter int PREAMBLE_BITS = 16,
  parameter int GUARD_BITS    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PACKET_WIDTH-1:0][7:0] packet,
  input  logic                         packet_valid,
  input  logic                         ovr_clr,
  output logic                         tx_bit,
  output logic                         tx_valid,
  output logic                         bit_strobe,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun
);

  localparam int PAY_BITS = 8 * PACKET_WIDTH;
  localparam int MAX_A    = (PREAMBLE_BITS > PAY_BITS) ? PREAMBLE_BITS : PAY_BITS;
  localparam int MAX_B    = (GUARD_BITS > 8) ? GUARD_BITS : 8;
  localparam int MAX_BITS = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int BW       = $clog2(MAX_BITS + 1);
  localparam int PIW      = $clog2(PAY_BITS);

  localparam logic [BW-1:0] PRE_LAST   = BW'(PREAMBLE_BITS - 1);
  localparam logic [BW-1:0] BYTE_LAST  = BW'(7);
  localparam logic [BW-1:0] PAY_LAST   = BW'(PAY_BITS - 1);
  localparam logic [BW-1:0] GUARD_LAST = BW'(GUARD_BITS - 1);

  tx_state_e           state_q, state_d;
  logic                pv_q;
  logic [PAY_BITS-1:0] shadow_q, shadow_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                overrun_q, overrun_d;

  logic          pv_rise;
  logic          accept;
  logic          tmr_restart;
  logic          tmr_strobe;
  logic          tmr_end;
  logic [BW-1:0] last_idx;
  logic          last_bit;
  logic [PIW-1:0] pay_idx;

  assign pv_rise = packet_valid & ~pv_q;
  assign accept  = pv_rise & (state_q == IDLE);
  assign pay_idx = bit_cnt_q[PIW-1:0];

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk          (clk),
    .rst          (rst),
    .restart_i    (tmr_restart),
    .bit_strobe_o (tmr_strobe),
    .bit_end_o    (tmr_end)
  );

  // Index of the final bit of the current state
  always_comb begin
    last_idx = '0;
    case (state_q)
      PREAMBLE: last_idx = PRE_LAST;
      SYNC:     last_idx = BYTE_LAST;
      PAYLOAD:  last_idx = PAY_LAST;
`ifdef PACKET_TX_CRC8_EN
      CRC:      last_idx = BYTE_LAST;
`endif
      GUARD:    last_idx = GUARD_LAST;
      default:  last_idx = '0;
    endcase
  end

  assign last_bit = tmr_end && (bit_cnt_q == last_idx) && (state_q != IDLE);

  // Frame state progression; every state ends on the last cycle of its last bit
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (pv_rise)  state_d = PREAMBLE;
      PREAMBLE: if (last_bit) state_d = SYNC;
      SYNC:     if (last_bit) state_d = PAYLOAD;
`ifdef PACKET_TX_CRC8_EN
      PAYLOAD:  if (last_bit) state_d = CRC;
      CRC:      if (last_bit) state_d = GUARD;
`else
      PAYLOAD:  if (last_bit) state_d = GUARD;
`endif
      GUARD:    if (last_bit) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Timer and bit counter restart on every state entry and stay parked in IDLE
  assign tmr_restart = (state_d != state_q) || (state_q == IDLE);

  // Bit counter advances once per bit period within a state
  always_comb begin
    if (tmr_restart) begin
      bit_cnt_d = '0;
    end else if (tmr_end) begin
      bit_cnt_d = bit_cnt_q + BW'(1);
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
  end

  // Shadow capture on acceptance and sticky overrun (a new overrun beats a clear)
  always_comb begin
    shadow_d  = accept ? packet : shadow_q;
    overrun_d = overrun_q;
    if (pv_rise && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else if (ovr_clr) begin
      overrun_d = 1'b0;
    end
  end

  // Main state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pv_q      <= 1'b0;
      shadow_q  <= '0;
      bit_cnt_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pv_q      <= packet_valid;
      shadow_q  <= shadow_d;
      bit_cnt_q <= bit_cnt_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef PACKET_TX_CRC8_EN
  logic [7:0] crc_q, crc_d;

  // CRC runs over payload bits in MSB-first order of each byte, one step per payload bit
  always_comb begin
    crc_d = crc_q;
    if (accept) begin
      crc_d = CRC8_INIT;
    end else if ((state_q == PAYLOAD) && tmr_strobe) begin
      crc_d = crc8_step(crc_q, shadow_q[pay_idx ^ PIW'(7)]);
    end
  end

  // CRC accumulator register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end
`endif

  // Serial bit select; all bytes go LSB first, payload byte 0 first
  always_comb begin
    tx_bit = 1'b0;
    case (state_q)
      PREAMBLE: tx_bit = ~bit_cnt_q[0];
      SYNC:     tx_bit = SYNC_WORD[bit_cnt_q[2:0]];
      PAYLOAD:  tx_bit = shadow_q[pay_idx];
`ifdef PACKET_TX_CRC8_EN
      CRC:      tx_bit = crc_q[bit_cnt_q[2:0]];
`endif
      default:  tx_bit = 1'b0;
    endcase
  end

  // Frame-valid decode straight from state so reset removes it without a clock
  always_comb begin
    tx_valid = 1'b0;
    case (state_q)
      PREAMBLE, SYNC, PAYLOAD: tx_valid = 1'b1;
`ifdef PACKET_TX_CRC8_EN
      CRC:                     tx_valid = 1'b1;
`endif
      default:                 tx_valid = 1'b0;
    endcase
  end

  assign bit_strobe = tx_valid & tmr_strobe;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == GUARD) & last_bit;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_packet_tx_sequencer.sv
// Directed bench for packet_tx_sequencer: table of frames plus reset/overrun corner sequences.
// Latency: checks first bit one cycle after acceptance and done on the final guard cycle.
// Backpressure: exercises overrun on edges while busy, in the done cycle and in first IDLE.
module tb_packet_tx_sequencer;

  localparam int PW  = 2;
  localparam int CPB = 4;
  localparam int PRE = 8;
  localparam int GB  = 2;
`ifdef PACKET_TX_CRC8_EN
  localparam int FRAME_BITS = PRE + 8 + 8 * PW + 8;
`else
  localparam int FRAME_BITS = PRE + 8 + 8 * PW;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [PW-1:0][7:0] packet = '0;
  logic               packet_valid = 1'b0;
  logic               ovr_clr = 1'b0;
  logic               tx_bit, tx_valid, bit_strobe, busy, done, overrun;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] pkt;
    logic [15:0] pay_bits;  // payload in transmission order, first bit at MSB
    logic [7:0]  crc_bits;  // CRC in transmission order, first bit at MSB
    int          hold;      // cycles packet_valid stays high
    int          inj;       // valid-cycle index of a second edge, -1 for none
  } vec_t;

  vec_t vecs[4];

  packet_tx_sequencer #(
    .PACKET_WIDTH  (PW),
    .CLKS_PER_BIT  (CPB),
    .PREAMBLE_BITS (PRE),
    .GUARD_BITS    (GB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .packet       (packet),
    .packet_valid (packet_valid),
    .ovr_clr      (ovr_clr),
    .tx_bit       (tx_bit),
    .tx_valid     (tx_valid),
    .bit_strobe   (bit_strobe),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Raise packet_valid at the current negedge and follow the whole frame.
  // Returns at the negedge after busy falls, or in the done cycle when stop_at_done is set.
  task automatic run_frame(input vec_t v, input bit stop_at_done);
    logic [47:0] cap;
    logic [47:0] exp;
    logic [39:0] full;
    logic        last_b;
    int          vcnt;
    int          bad_s;
    int          bad_g;
    int          gcnt;
    cap    = '0;
    last_b = 1'b0;
    bad_s  = 0;
    bad_g  = 0;
    full   = {8'b10101010, 8'b11001011, v.pay_bits, v.crc_bits};
`ifdef PACKET_TX_CRC8_EN
    exp = {8'h00, full};
`else
    exp = {16'h0000, full[39:8]};
`endif
    packet       = v.pkt;
    packet_valid = 1'b1;
    @(negedge clk);
    chk("first_bit_valid_strobe", {tx_valid, bit_strobe}, 2'b11);
    vcnt = 0;
    while (tx_valid && vcnt < 400) begin
      if (bit_strobe) cap = {cap[46:0], tx_bit};
      if (bit_strobe !== (vcnt % CPB == 0)) bad_s++;
      if (!bit_strobe && (tx_bit !== last_b)) bad_s++;
      if (!busy) bad_s++;
      last_b = tx_bit;
      if (vcnt == v.hold - 1) packet_valid = 1'b0;
      if (v.inj >= 0) begin
        if (vcnt == v.inj) begin
          packet_valid = 1'b1;
        end else if (vcnt == v.inj + 1) begin
          chk("overrun_set_busy", overrun, 1);
          packet_valid = 1'b0;
          ovr_clr      = 1'b1;
        end else if (vcnt == v.inj + 2) begin
          chk("overrun_clear", overrun, 0);
          ovr_clr = 1'b0;
        end
      end
      vcnt++;
      @(negedge clk);
    end
    chk("valid_len", vcnt, FRAME_BITS * CPB);
    chk("frame_bits", cap, exp);
    chk("strobe_cadence", bad_s, 0);
    gcnt = 0;
    while (!done && gcnt < 50) begin
      if (tx_valid || tx_bit || bit_strobe || !busy) bad_g++;
      gcnt++;
      @(negedge clk);
    end
    if (tx_valid || tx_bit || bit_strobe || !busy) bad_g++;
    chk("done_pos", gcnt, GB * CPB - 1);
    chk("guard_sig", bad_g, 0);
    chk("overrun_end", overrun, 0);
    if (!stop_at_done) begin
      @(negedge clk);
      chk("busy_fall", {busy, done, tx_valid}, 3'b000);
    end
  endtask

  initial begin
    int bad;
    vecs[0] = '{16'h3CA5, 16'b1010010100111100, 8'b10110111, 1, -1};
    vecs[1] = '{16'h0000, 16'b0000000000000000, 8'b00000000, 20, -1};
    vecs[2] = '{16'h0001, 16'b1000000000000000, 8'b10101000, 3, -1};
    vecs[3] = '{16'hFF80, 16'b0000000111111111, 8'b10100010, 2, 70};

    // Reset state
    @(negedge clk);
    chk("reset_outputs", {tx_bit, tx_valid, bit_strobe, busy, done, overrun}, 6'b0);
    rst = 1'b0;
    @(negedge clk);

    // Table of frames (includes long packet_valid hold and overrun during payload)
    for (int v = 0; v < 4; v++) begin
      run_frame(vecs[v], 1'b0);
      if (v == 1) begin
        bad = 0;
        for (int i = 0; i < 5; i++) begin
          if (busy || overrun) bad++;
          @(negedge clk);
        end
        chk("single_frame_on_hold", bad, 0);
      end
    end

    // Reset during SYNC after an overrun
    packet       = 16'h3CA5;
    packet_valid = 1'b1;
    @(negedge clk);
    packet_valid = 1'b0;
    for (int i = 0; i < 10; i++) @(negedge clk);
    packet_valid = 1'b1;
    @(negedge clk);
    packet_valid = 1'b0;
    chk("overrun_preamble", overrun, 1);
    for (int i = 0; i < 29; i++) @(negedge clk);
    chk("in_sync_busy", {tx_valid, busy}, 2'b11);
    rst = 1'b1;
    #1;
    chk("rst_async", {tx_valid, busy, overrun, done, bit_strobe, tx_bit}, 6'b0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done || busy) bad++;
    end
    chk("rst_hold_no_done", bad, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", {busy, tx_valid, overrun}, 3'b000);
    run_frame(vecs[0], 1'b0);

    // Edge in the done cycle, with a simultaneous clear: overrun must still set
    run_frame(vecs[2], 1'b1);
    packet_valid = 1'b1;
    ovr_clr      = 1'b1;
    @(negedge clk);
    chk("done_edge_overrun", overrun, 1);
    chk("done_edge_first_idle", busy, 0);
    packet_valid = 1'b0;
    ovr_clr      = 1'b0;
    @(negedge clk);
    chk("done_edge_no_frame", busy, 0);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    chk("ovr_clr_idle", overrun, 0);

    // Edge in the first IDLE cycle is accepted
    run_frame(vecs[0], 1'b1);
    @(negedge clk);
    chk("first_idle_not_busy", busy, 0);
    run_frame(vecs[2], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
